// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep checker: reference gate mode codes and FSM states.
package gate_pkg;

  localparam logic [1:0] GM_AND  = 2'd0;
  localparam logic [1:0] GM_OR   = 2'd1;
  localparam logic [1:0] GM_XOR  = 2'd2;
  localparam logic [1:0] GM_NAND = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Control/result bundle of the gate sweep checker; the checker is the slave, the environment
// (sequencer plus the gate under test feeding dut_y) is the master.
interface gate_sweep_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [1:0]      mode;
  logic            dut_y;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    output start, mode, dut_y,
    input  vec_out, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    input  start, mode, dut_y,
    output vec_out, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/nin_gate.sv
// Combinational N-input reference gate selectable between AND, OR, XOR and NAND.
module nin_gate
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] v,
  input  logic [1:0]      mode,
  output logic            y
);

  always_comb begin
    case (mode)
      GM_AND:  y = &v;
      GM_OR:   y = |v;
      GM_XOR:  y = ^v;
      default: y = ~&v;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Gate self-test engine: sweeps every input vector into an external gate, samples its output
// on the last dwell clock and compares against the internal reference gate.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 4
) (
  input logic                 clk,
  input logic                 rst,
  gate_sweep_checker_if.slave bus
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      mode_l;
  logic [N_IN-1:0] vec;
  logic [N_IN:0]   err, err_nxt;
  logic            busy, done, pass, fail_valid;
  logic [N_IN-1:0] fail_vec;
  logic            ref_y, launch, sample, finish, mismatch;

  nin_gate #(.N_IN(N_IN)) u_ref (
    .v    (vec),
    .mode (mode_l),
    .y    (ref_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    sample    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt == CNT_LAST) begin
          sample = 1'b1;
          if (vec == VEC_LAST) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // dut_y only matters on the sample clock; earlier dwell clocks are settle time.
  assign mismatch = sample && (bus.dut_y != ref_y);
  assign err_nxt  = err + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      mode_l     <= GM_AND;
      vec        <= '0;
      err        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= finish;
      if (launch) begin
        mode_l     <= bus.mode;
        vec        <= '0;
        cnt        <= '0;
        err        <= '0;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
        busy       <= 1'b1;
      end else if (state == S_DRIVE) begin
        err <= err_nxt;
        if (mismatch && !fail_valid) begin
          fail_vec   <= vec;
          fail_valid <= 1'b1;
        end
        if (sample) begin
          cnt <= '0;
          if (finish) begin
            // err_nxt includes a mismatch on the final vector
            busy <= 1'b0;
            pass <= (err_nxt == '0);
          end else begin
            vec <= vec + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.vec_out    = vec;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: time-indexed reference model checked every cycle, directed
// scenarios with literal expectations, randomized sweeps, and a second N_IN=3/DWELL=2 instance.
module tb_gate_sweep_checker;
  import gate_pkg::*;

  localparam int N  = 2;
  localparam int DW = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if #(.N_IN(2)) bus ();
  gate_sweep_checker_if #(.N_IN(3)) bus3 ();

  gate_sweep_checker #(.N_IN(2), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gate_sweep_checker #(.N_IN(3), .DWELL(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Gate under test for the main instance: loopback gate, stuck-at, or random output
  int         kind = 0;
  logic [1:0] gmode = 2'd0;
  logic       rnd_bit = 1'b0;
  logic       loop_y;

  nin_gate #(.N_IN(2)) u_loop (
    .v    (bus.vec_out),
    .mode (gmode),
    .y    (loop_y)
  );

  always_comb begin
    case (kind)
      0:       bus.dut_y = loop_y;
      1:       bus.dut_y = 1'b0;
      2:       bus.dut_y = 1'b1;
      default: bus.dut_y = rnd_bit;
    endcase
  end

  assign bus3.dut_y = 1'b1;
  assign bus3.mode  = 2'd3;

  always begin
    @(negedge clk);
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference gate from the count of ones in the vector
  function automatic bit ref_fn(input int m, input int v, input int n);
    int ones;
    ones = $countones(v);
    case (m)
      0:       return ones == n;
      1:       return ones != 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  // Model: t counts clocks since the start edge; vector t/DW is on the bus, and the
  // sample for vector v falls on t == (v+1)*DW.
  bit m_run = 0, m_busy = 0, m_done = 0, m_pass = 0, m_fvalid = 0;
  int m_t = 0, m_mode = 0, m_err = 0, m_fv = 0, m_vec = 0, m_v = 0;

  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_busy = 0; m_done = 0; m_pass = 0; m_fvalid = 0;
      m_t = 0; m_mode = 0; m_err = 0; m_fv = 0; m_vec = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_t++;
        if (m_t % DW == 0) begin
          m_v = m_t / DW - 1;
          if (bus.dut_y != ref_fn(m_mode, m_v, N)) begin
            m_err++;
            if (!m_fvalid) begin
              m_fvalid = 1;
              m_fv     = m_v;
            end
          end
        end
        if (m_t == S * DW) begin
          m_run  = 0;
          m_busy = 0;
          m_done = 1;
          m_pass = (m_err == 0);
        end else begin
          m_vec = m_t / DW;
        end
      end else if (bus.start) begin
        m_run = 1; m_t = 0; m_mode = int'(bus.mode); m_vec = 0;
        m_err = 0; m_fvalid = 0; m_pass = 0; m_busy = 1;
      end
    end
  end

  always begin
    @(negedge clk);
    chk("vec_out",    int'(bus.vec_out),    m_vec);
    chk("busy",       int'(bus.busy),       int'(m_busy));
    chk("done",       int'(bus.done),       int'(m_done));
    chk("pass",       int'(bus.pass),       int'(m_pass));
    chk("err_count",  int'(bus.err_count),  m_err);
    chk("fail_valid", int'(bus.fail_valid), int'(m_fvalid));
    chk("fail_vec",   int'(bus.fail_vec),   m_fv);
  end

  task automatic launch(input int k_kind, input logic [1:0] gm, input logic [1:0] md,
                        output int k0);
    @(negedge clk);
    kind      = k_kind;
    gmode     = gm;
    bus.mode  = md;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k0 = edge_cnt;
  endtask

  // lat = edge that samples the done pulse, relative to the start edge
  task automatic wait_done(input int k0, input bit noise, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        lat = edge_cnt + 1 - k0;
        break;
      end
      if (noise && bus.busy) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.mode  = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic sweep(input int k_kind, input logic [1:0] gm, input logic [1:0] md,
                       input bit noise, output int lat);
    int k0;
    launch(k_kind, gm, md, k0);
    wait_done(k0, noise, lat);
  endtask

  initial begin
    int lat, k0, rk, rg, rm;
    bus.start  = 1'b0;
    bus.mode   = 2'd0;
    bus3.start = 1'b0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vec_out", int'(bus.vec_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err", int'(bus.err_count), 0);
    chk("rst_fail_valid", int'(bus.fail_valid), 0);
    chk("rst3_vec_out", int'(bus3.vec_out), 0);
    chk("rst3_err", int'(bus3.err_count), 0);
    rst = 1'b0;

    // Loopback AND gate, AND mode
    sweep(0, 2'd0, 2'd0, 1'b0, lat);
    chk("t1_latency", lat, 17);
    chk("t1_pass", int'(bus.pass), 1);
    chk("t1_err", int'(bus.err_count), 0);
    chk("t1_fail_valid", int'(bus.fail_valid), 0);
    chk("t1_vec_hold", int'(bus.vec_out), 3);

    // Stuck-at-0 gate, AND mode
    sweep(1, 2'd0, 2'd0, 1'b0, lat);
    chk("t2_err", int'(bus.err_count), 1);
    chk("t2_fail_vec", int'(bus.fail_vec), 3);
    chk("t2_pass", int'(bus.pass), 0);
    chk("t2_model_err", m_err, 1);

    // AND gate checked against XOR reference
    sweep(0, 2'd0, 2'd2, 1'b0, lat);
    chk("t3_err", int'(bus.err_count), 3);
    chk("t3_fail_vec", int'(bus.fail_vec), 1);
    chk("t3_pass", int'(bus.pass), 0);
    chk("t3_model_fv", m_fv, 1);

    // Restart and mode change during a sweep are ignored
    launch(0, 2'd0, 2'd0, k0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 2'd1;
    wait_done(k0, 1'b0, lat);
    chk("t4_latency", lat, 17);
    chk("t4_err", int'(bus.err_count), 0);
    chk("t4_pass", int'(bus.pass), 1);

    // Reset mid-sweep aborts immediately, then a clean sweep
    launch(1, 2'd0, 2'd0, k0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_vec", int'(bus.vec_out), 0);
    chk("t5_rst_err", int'(bus.err_count), 0);
    chk("t5_rst_done", int'(bus.done), 0);
    chk("t5_rst_fail_valid", int'(bus.fail_valid), 0);
    chk("t5_rst_fail_vec", int'(bus.fail_vec), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep(0, 2'd1, 2'd1, 1'b0, lat);
    chk("t5_latency", lat, 17);
    chk("t5_pass", int'(bus.pass), 1);

    // Randomized sweeps with start/mode noise while busy
    for (int it = 0; it < 12; it++) begin
      rk = $urandom_range(0, 3);
      rg = $urandom_range(0, 3);
      rm = (it % 3 == 0) ? rg : $urandom_range(0, 3);
      sweep(rk, 2'(rg), 2'(rm), 1'b1, lat);
      chk("rnd_latency", lat, 17);
      if (rk == 0 && rg == rm) chk("rnd_loop_pass", int'(bus.pass), 1);
    end

    // Second instance: N_IN=3, DWELL=2, stuck-at-1 against NAND
    @(negedge clk);
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    k0  = edge_cnt;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus3.done) begin
        lat = edge_cnt + 1 - k0;
        break;
      end
      @(negedge clk);
    end
    chk("t6_latency", lat, 17);
    chk("t6_err", int'(bus3.err_count), 1);
    chk("t6_fail_vec", int'(bus3.fail_vec), 7);
    chk("t6_fail_valid", int'(bus3.fail_valid), 1);
    chk("t6_pass", int'(bus3.pass), 0);
    @(negedge clk);
    chk("t6_busy_after", int'(bus3.busy), 0);
    chk("t6_done_pulse", int'(bus3.done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "watchdog");
  end

endmodule
